// File: rtl/wb_trace_capture.sv
// Writeback retirement tracer: captures tiny_risc writeback events into a lossy FIFO
// with a registered valid/ready output. Define WB_TRACE_CYCLE_STAMP_EN to add a 16-bit cycle stamp.
module wb_trace_capture #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [3:0]               wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [3:0]               trace_rd,
  output logic [DATA_W-1:0]        trace_data,
`ifdef WB_TRACE_CYCLE_STAMP_EN
  output logic [15:0]              trace_stamp,
`endif
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     overflow_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef WB_TRACE_CYCLE_STAMP_EN
  localparam int EW = 4 + DATA_W + 16;
`else
  localparam int EW = 4 + DATA_W;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] out_q;
  logic [EW-1:0] in_entry;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] mem_cnt;
  logic          out_valid;
  logic          pop, push, drop, out_load, mem_nonempty, mem_wr, mem_rd;

`ifdef WB_TRACE_CYCLE_STAMP_EN
  logic [15:0] stamp_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stamp_cnt <= '0;
    else       stamp_cnt <= stamp_cnt + 16'd1;
  end

  assign in_entry    = {stamp_cnt, wb_rd, wb_data};
  assign trace_stamp = out_q[DATA_W+4 +: 16];
`else
  assign in_entry    = {wb_rd, wb_data};
`endif

  assign trace_valid = out_valid;
  assign trace_rd    = out_q[DATA_W +: 4];
  assign trace_data  = out_q[DATA_W-1:0];
  assign level       = mem_cnt + CW'(out_valid);

  // The output register counts as one FIFO slot; an event bypasses storage
  // straight into it whenever storage is empty and the register is free.
  always_comb begin
    pop          = out_valid & trace_ready;
    push         = wb_valid & ((level < CW'(DEPTH)) | pop);
    drop         = wb_valid & ~push;
    out_load     = ~out_valid | pop;
    mem_nonempty = (mem_cnt != '0);
    mem_wr       = push & (~out_load | mem_nonempty);
    mem_rd       = out_load & mem_nonempty;
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + AW'(1);
      if (mem_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({mem_wr, mem_rd})
        2'b10:   mem_cnt <= mem_cnt + CW'(1);
        2'b01:   mem_cnt <= mem_cnt - CW'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      if (out_load) begin
        if (mem_rd) begin
          out_q     <= mem[rd_ptr];
          out_valid <= 1'b1;
        end else if (push) begin
          out_q     <= in_entry;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (overflow_clr)           drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_wb_trace_capture.sv
// Directed self-checking bench for wb_trace_capture (works with or without WB_TRACE_CYCLE_STAMP_EN).
module tb_wb_trace_capture;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;

  logic        clk, reset, wb_valid, trace_ready, overflow_clr;
  logic [3:0]  wb_rd, trace_rd;
  logic [31:0] wb_data, trace_data;
  logic        trace_valid, overflow;
  logic [3:0]  level;
  logic [7:0]  drop_cnt;
`ifdef WB_TRACE_CYCLE_STAMP_EN
  logic [15:0] trace_stamp;
`endif

  int checks = 0;
  int errors = 0;
  int edges;

  wb_trace_capture #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_rd(trace_rd),
    .trace_data(trace_data),
`ifdef WB_TRACE_CYCLE_STAMP_EN
    .trace_stamp(trace_stamp),
`endif
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .overflow_clr(overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count: equals the DUT stamp counter value just before each edge.
  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic test_reset();
    reset = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    trace_ready = 1'b0; overflow_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", trace_valid); end
    checks++; if (trace_rd !== 4'd0) begin errors++; $display("[TB] FAIL reset_rd: got %0h expected 0", trace_rd); end
    checks++; if (trace_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", trace_data); end
    checks++; if (level !== 4'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %0b expected 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
`ifdef WB_TRACE_CYCLE_STAMP_EN
    checks++; if (trace_stamp !== 16'd0) begin errors++; $display("[TB] FAIL reset_stamp: got %0h expected 0", trace_stamp); end
`endif
  endtask

  task automatic test_single();
    int st;
    wb_valid = 1'b1; wb_rd = 4'd3; wb_data = 32'h0000_000A; trace_ready = 1'b1;
    st = edges;
    @(negedge clk);
    wb_valid = 1'b0;
    checks++; if (trace_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %0b expected 1", trace_valid); end
    checks++; if (trace_rd !== 4'd3) begin errors++; $display("[TB] FAIL single_rd: got %0h expected 3", trace_rd); end
    checks++; if (trace_data !== 32'hA) begin errors++; $display("[TB] FAIL single_data: got %0h expected a", trace_data); end
    checks++; if (level !== 4'd1) begin errors++; $display("[TB] FAIL single_level: got %0d expected 1", level); end
`ifdef WB_TRACE_CYCLE_STAMP_EN
    checks++; if (trace_stamp !== 16'(st)) begin errors++; $display("[TB] FAIL single_stamp: got %0h expected %0h", trace_stamp, 16'(st)); end
`endif
    @(negedge clk);
    checks++; if (trace_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("[TB] FAIL single_drained: got valid %0b level %0d expected 0 0", trace_valid, level); end
  endtask

  task automatic test_fill_overflow();
    logic [15:0] st [10];
    int exp_level;
    trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wb_valid = 1'b1; wb_rd = 4'(i + 1); wb_data = 32'h10 + 32'(i);
      st[i] = 16'(edges);
      @(negedge clk);
      exp_level = (i < 8) ? i + 1 : 8;
      checks++; if (level !== 4'(exp_level)) begin errors++; $display("[TB] FAIL fill_level[%0d]: got %0d expected %0d", i, level, exp_level); end
      checks++; if (overflow !== (i >= 8)) begin errors++; $display("[TB] FAIL fill_overflow[%0d]: got %0b expected %0b", i, overflow, (i >= 8)); end
    end
    wb_valid = 1'b0;
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("[TB] FAIL fill_drop_cnt: got %0d expected 2", drop_cnt); end
    trace_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (trace_valid !== 1'b1 || trace_rd !== 4'(k + 1) || trace_data !== 32'h10 + 32'(k)) begin
        errors++;
        $display("[TB] FAIL fill_drain[%0d]: got v=%0b rd=%0h data=%0h expected v=1 rd=%0h data=%0h",
                 k, trace_valid, trace_rd, trace_data, k + 1, 32'h10 + 32'(k));
      end
`ifdef WB_TRACE_CYCLE_STAMP_EN
      checks++; if (trace_stamp !== st[k]) begin errors++; $display("[TB] FAIL fill_stamp[%0d]: got %0h expected %0h", k, trace_stamp, st[k]); end
`endif
      @(negedge clk);
    end
    checks++; if (level !== 4'd0 || trace_valid !== 1'b0) begin errors++; $display("[TB] FAIL fill_empty: got level %0d valid %0b expected 0 0", level, trace_valid); end
  endtask

  task automatic test_full_pushpop();
    int exp_rd [8] = '{1, 2, 3, 4, 5, 6, 7, 9};
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wb_valid = 1'b1; wb_rd = 4'(i); wb_data = 32'h100 + 32'(i);
      @(negedge clk);
    end
    checks++; if (level !== 4'd8) begin errors++; $display("[TB] FAIL full_level: got %0d expected 8", level); end
    trace_ready = 1'b1; wb_valid = 1'b1; wb_rd = 4'd9; wb_data = 32'h1FF;
    @(negedge clk);
    wb_valid = 1'b0;
    checks++; if (level !== 4'd8) begin errors++; $display("[TB] FAIL full_pushpop_level: got %0d expected 8", level); end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("[TB] FAIL full_pushpop_drop: got %0d expected 2", drop_cnt); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (trace_valid !== 1'b1 || trace_rd !== 4'(exp_rd[k])) begin
        errors++;
        $display("[TB] FAIL full_order[%0d]: got v=%0b rd=%0h expected v=1 rd=%0h", k, trace_valid, trace_rd, exp_rd[k]);
      end
      @(negedge clk);
    end
    checks++; if (level !== 4'd0) begin errors++; $display("[TB] FAIL full_empty: got %0d expected 0", level); end
  endtask

  task automatic test_clear_drop();
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL clear_plain: got ovf %0b cnt %0d expected 0 0", overflow, drop_cnt); end
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wb_valid = 1'b1; wb_rd = 4'(i); wb_data = 32'h200 + 32'(i);
      @(negedge clk);
    end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL clear_fill_nodrop: got %0d expected 0", drop_cnt); end
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL clear_vs_drop: got ovf %0b cnt %0d expected 1 1", overflow, drop_cnt); end
    repeat (253) @(negedge clk);
    checks++; if (drop_cnt !== 8'd254) begin errors++; $display("[TB] FAIL drop_254: got %0d expected 254", drop_cnt); end
    @(negedge clk);
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("[TB] FAIL drop_255: got %0d expected 255", drop_cnt); end
    repeat (46) @(negedge clk);
    checks++; if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin errors++; $display("[TB] FAIL drop_saturate: got cnt %0d ovf %0b expected 255 1", drop_cnt, overflow); end
    wb_valid = 1'b0; trace_ready = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (level !== 4'd0 || trace_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear_drain: got level %0d valid %0b expected 0 0", level, trace_valid); end
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL clear_final: got ovf %0b cnt %0d expected 0 0", overflow, drop_cnt); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    logic stalled = 1'b0;
    logic [3:0] prd = '0;
    logic [31:0] pdata = '0;
`ifdef WB_TRACE_CYCLE_STAMP_EN
    logic [15:0] pst = '0;
`endif
    for (int c = 0; c < 100 && got < 20; c++) begin
      if (stalled) begin
        checks++;
        if (trace_valid !== 1'b1 || trace_rd !== prd || trace_data !== pdata) begin
          errors++;
          $display("[TB] FAIL stall_hold[%0d]: got v=%0b rd=%0h data=%0h expected v=1 rd=%0h data=%0h",
                   c, trace_valid, trace_rd, trace_data, prd, pdata);
        end
`ifdef WB_TRACE_CYCLE_STAMP_EN
        checks++; if (trace_stamp !== pst) begin errors++; $display("[TB] FAIL stall_stamp[%0d]: got %0h expected %0h", c, trace_stamp, pst); end
`endif
      end
      trace_ready = (c % 2 == 0);
      if (trace_valid && trace_ready) begin
        checks++;
        if (trace_data !== 32'(got) || trace_rd !== 4'(got)) begin
          errors++;
          $display("[TB] FAIL stream[%0d]: got rd=%0h data=%0h expected rd=%0h data=%0h",
                   got, trace_rd, trace_data, 4'(got), got);
        end
        got++;
      end
      stalled = trace_valid && !trace_ready;
      prd = trace_rd; pdata = trace_data;
`ifdef WB_TRACE_CYCLE_STAMP_EN
      pst = trace_stamp;
`endif
      if (sent < 20 && (c < 12 || c % 2 == 0)) begin
        wb_valid = 1'b1; wb_rd = 4'(sent); wb_data = 32'(sent);
        sent++;
      end else begin
        wb_valid = 1'b0;
      end
      @(negedge clk);
    end
    wb_valid = 1'b0;
    checks++; if (got !== 20) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 20", got); end
    checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL stream_nodrop: got cnt %0d ovf %0b expected 0 0", drop_cnt, overflow); end
    checks++; if (level !== 4'd0) begin errors++; $display("[TB] FAIL stream_empty: got %0d expected 0", level); end
  endtask

  task automatic test_reset_midstall();
    int st;
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wb_valid = 1'b1; wb_rd = 4'(i + 1); wb_data = 32'h50 + 32'(i);
      @(negedge clk);
    end
    wb_valid = 1'b0;
    checks++; if (level !== 4'd5) begin errors++; $display("[TB] FAIL midstall_level: got %0d expected 5", level); end
    #2 reset = 1'b1;
    #1;
    checks++; if (trace_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("[TB] FAIL async_reset: got valid %0b level %0d expected 0 0", trace_valid, level); end
    @(negedge clk);
    reset = 1'b0;
    wb_valid = 1'b1; wb_rd = 4'hC; wb_data = 32'hDEAD_BEEF;
    st = edges;
    @(negedge clk);
    wb_valid = 1'b0;
    checks++;
    if (trace_valid !== 1'b1 || trace_rd !== 4'hC || trace_data !== 32'hDEAD_BEEF || level !== 4'd1) begin
      errors++;
      $display("[TB] FAIL post_reset_event: got v=%0b rd=%0h data=%0h level=%0d expected v=1 rd=c data=deadbeef level=1",
               trace_valid, trace_rd, trace_data, level);
    end
`ifdef WB_TRACE_CYCLE_STAMP_EN
    checks++; if (trace_stamp !== 16'(st)) begin errors++; $display("[TB] FAIL post_reset_stamp: got %0h expected %0h", trace_stamp, 16'(st)); end
`endif
    trace_ready = 1'b1;
    @(negedge clk);
    checks++; if (trace_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("[TB] FAIL post_reset_drain: got valid %0b level %0d expected 0 0", trace_valid, level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_pushpop();
    test_clear_drop();
    test_back_to_back();
    test_reset_midstall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
